// File: rtl/async_fifo_read_pkg.sv
// Shared types and elaboration checks for the async FIFO read-side drain engine.
//   state_e          : drain FSM states
//   READ_LATENCY_*   : legal pop-to-data latency range
//   buf_depth_ok()   : local buffer must be a power of two and cover the read pipeline
package async_fifo_read_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  function automatic bit read_latency_ok(int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit buf_depth_ok(int unsigned depth, int unsigned lat);
    return is_pow2(depth) && (depth >= lat + 1);
  endfunction

endpackage

// File: rtl/fifo_read_skid_buf.sv
// Circular output buffer with occupancy count.
//   clk, rst : clock and synchronous active-high reset
//   push_i   : write wdata_i at the write pointer
//   pop_i    : retire the entry at the read pointer
//   rdata_o  : entry at the read pointer (registered storage, no bypass)
//   count_o  : number of valid entries
module fifo_read_skid_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  // Simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && (count_q == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && (count_q == '0)));

endmodule

// File: rtl/async_fifo_read_drain.sv
// Read-domain drain engine: pops a requested number of words from the async FIFO
// and streams them out as valid/ready beats with a last marker.
//   read_clk, read_reset        : clock and synchronous active-high reset
//   read_fifo_pop / read_data / read_fifo_empty : FIFO read channel
//   req_valid / req_len / req_ready             : drain request handshake
//   out_valid / out_data / out_ready / out_last : output stream
//   busy, words_left                            : status
module async_fifo_read_drain
  import async_fifo_read_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned BUF_DEPTH       = 4,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                       read_clk,
  input  logic                       read_reset,
  output logic                       read_fifo_pop,
  input  logic [FIFO_DATA_WIDTH-1:0] read_data,
  input  logic                       read_fifo_empty,
  input  logic                       req_valid,
  input  logic [LEN_WIDTH-1:0]       req_len,
  output logic                       req_ready,
  output logic                       out_valid,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic [LEN_WIDTH-1:0]       words_left
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (!buf_depth_ok(BUF_DEPTH, READ_LATENCY)) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of two and at least READ_LATENCY+1");
  end

  state_e                     state_q, state_d;
  logic [LEN_WIDTH-1:0]       pop_rem_q, pop_rem_d;
  logic [LEN_WIDTH-1:0]       words_left_q, words_left_d;
  logic [READ_LATENCY-1:0]    tag_q, tag_d;
  logic [CNT_W-1:0]           count, inflight;
  logic [FIFO_DATA_WIDTH-1:0] buf_rdata;
  logic                       pop_c, capture_c, credit_c, buf_valid_c, beat_c, last_c;

  // Pop tags ripple through a READ_LATENCY-deep shift register; the exiting tag
  // marks the cycle in which read_data carries the popped word.
  if (READ_LATENCY == 1) begin : g_tag_l1
    always_comb tag_d = pop_c;
  end else begin : g_tag_ln
    always_comb tag_d = {tag_q[READ_LATENCY-2:0], pop_c};
  end

  assign capture_c = tag_q[READ_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(tag_q[i]);
  end

  // Credit reserves buffer space for words still in the FIFO read pipeline.
  assign credit_c    = (count + inflight) < CNT_W'(BUF_DEPTH);
  assign buf_valid_c = (count != '0);
  assign beat_c      = buf_valid_c && out_ready;
  assign last_c      = buf_valid_c && (words_left_q == LEN_WIDTH'(1));

  // Next-state, pop and counter logic.
  always_comb begin
    state_d      = state_q;
    pop_rem_d    = pop_rem_q;
    words_left_d = words_left_q;
    pop_c        = 1'b0;
    if (beat_c) words_left_d = words_left_q - LEN_WIDTH'(1);
    unique case (state_q)
      IDLE: begin
        if (req_valid && (req_len != '0)) begin
          pop_rem_d    = req_len;
          words_left_d = req_len;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        pop_c = !read_fifo_empty && (pop_rem_q != '0) && credit_c;
        if (pop_c) begin
          pop_rem_d = pop_rem_q - LEN_WIDTH'(1);
          if (pop_rem_q == LEN_WIDTH'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (beat_c && last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      state_q      <= IDLE;
      pop_rem_q    <= '0;
      words_left_q <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      pop_rem_q    <= pop_rem_d;
      words_left_q <= words_left_d;
      tag_q        <= tag_d;
    end
  end

  fifo_read_skid_buf #(
    .DATA_W (FIFO_DATA_WIDTH),
    .DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clk     (read_clk),
    .rst     (read_reset),
    .push_i  (capture_c),
    .wdata_i (read_data),
    .pop_i   (beat_c),
    .rdata_o (buf_rdata),
    .count_o (count)
  );

  // All outputs are forced low while reset is held.
  assign read_fifo_pop = pop_c && !read_reset;
  assign req_ready     = (state_q == IDLE) && !read_reset;
  assign out_valid     = buf_valid_c && !read_reset;
  assign out_data      = read_reset ? '0 : buf_rdata;
  assign out_last      = last_c && !read_reset;
  assign busy          = (state_q != IDLE) && !read_reset;
  assign words_left    = read_reset ? '0 : words_left_q;

endmodule

// File: tb/tb_async_fifo_read_drain.sv
// Directed bench: dut1 runs READ_LATENCY=1, dut2 runs READ_LATENCY=2, each fed
// by its own behavioural FIFO model.
module tb_async_fifo_read_drain;

  localparam int unsigned W  = 32;
  localparam int unsigned LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          rst1, rst2, req_valid, out_ready, empty_force;
  logic [LW-1:0] req_len;

  logic          pop1, empty1, req_ready1, out_valid1, out_last1, busy1;
  logic [W-1:0]  rd1, out_data1;
  logic [LW-1:0] wl1;
  logic          pop2, empty2, req_ready2, out_valid2, out_last2, busy2;
  logic [W-1:0]  rd2, rd2_s1, out_data2;
  logic [LW-1:0] wl2;

  logic [W-1:0] mem1 [32];
  logic [W-1:0] mem2 [32];
  int rp1 = 0, wp1 = 0, rp2 = 0, wp2 = 0;

  int tests = 0, fails = 0;

  assign empty1 = (rp1 == wp1) || empty_force;
  assign empty2 = (rp2 == wp2) || empty_force;

  // FIFO models: data appears READ_LATENCY cycles after the pop.
  always @(posedge clk) begin
    if (pop1 && (rp1 != wp1)) begin rd1 <= mem1[rp1]; rp1 <= rp1 + 1; end
    else rd1 <= '0;
  end
  always @(posedge clk) begin
    if (pop2 && (rp2 != wp2)) begin rd2_s1 <= mem2[rp2]; rp2 <= rp2 + 1; end
    else rd2_s1 <= '0;
    rd2 <= rd2_s1;
  end

  async_fifo_read_drain #(.FIFO_DATA_WIDTH(W), .READ_LATENCY(1), .BUF_DEPTH(4), .LEN_WIDTH(LW)) dut1 (
    .read_clk(clk), .read_reset(rst1), .read_fifo_pop(pop1), .read_data(rd1),
    .read_fifo_empty(empty1), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .out_last(out_last1),
    .busy(busy1), .words_left(wl1));

  async_fifo_read_drain #(.FIFO_DATA_WIDTH(W), .READ_LATENCY(2), .BUF_DEPTH(4), .LEN_WIDTH(LW)) dut2 (
    .read_clk(clk), .read_reset(rst2), .read_fifo_pop(pop2), .read_data(rd2),
    .read_fifo_empty(empty2), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready), .out_last(out_last2),
    .busy(busy2), .words_left(wl2));

  // Monitors record pops and accepted beats mid-cycle.
  int np1 = 0, nb1 = 0, viol1 = 0, np2 = 0, nb2 = 0, viol2 = 0;
  int pcyc1 [64];
  int bcyc1 [64];
  logic [W-1:0]  bd1 [64];
  logic [W-1:0]  bd2 [64];
  logic          bl1 [64];
  logic          bl2 [64];
  logic          bb1 [64];
  logic [LW-1:0] bw1 [64];

  always @(negedge clk) begin
    if (pop1 === 1'b1) begin
      if (empty1) viol1++;
      if (np1 < 64) pcyc1[np1] = cyc;
      np1++;
    end
    if (out_valid1 === 1'b1 && out_ready === 1'b1 && nb1 < 64) begin
      bd1[nb1] = out_data1; bl1[nb1] = out_last1; bb1[nb1] = busy1;
      bw1[nb1] = wl1; bcyc1[nb1] = cyc; nb1++;
    end
    if (pop2 === 1'b1) begin
      if (empty2) viol2++;
      np2++;
    end
    if (out_valid2 === 1'b1 && out_ready === 1'b1 && nb2 < 64) begin
      bd2[nb2] = out_data2; bl2[nb2] = out_last2; nb2++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) mem1[wp1 + i] = base + W'(i);
    wp1 = wp1 + n;
  endtask

  task automatic load2(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) mem2[wp2 + i] = base + W'(i);
    wp2 = wp2 + n;
  endtask

  task automatic send_req(input logic [LW-1:0] len);
    req_valid = 1'b1;
    req_len   = len;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1; req_valid = 1'b1; req_len = 16'd4;
    out_ready = 1'b1; empty_force = 1'b0;
    load1(4, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({pop1, out_valid1, busy1, req_ready1} !== 4'b0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: pop/valid/busy/ready=%b expected 0000", i,
                 {pop1, out_valid1, busy1, req_ready1});
      end
    end
    req_valid = 1'b0;
    rst1 = 1'b0;
    #1;
    tests++;
    if (req_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: req_ready=%b busy=%b expected 1 0", req_ready1, busy1);
    end
    tests++;
    if (np1 !== 0) begin
      fails++;
      $display("FAIL reset_no_pop: pops=%0d expected 0", np1);
    end
  endtask

  task automatic test_basic();
    int p0, b0, g;
    logic [W-1:0] exp;
    p0 = np1; b0 = nb1; g = 0;
    send_req(16'd4);
    while (nb1 < b0 + 4 && g < 40) begin tick(); g++; end
    tests++;
    if (g >= 40) begin fails++; $display("FAIL basic_timeout: beats=%0d expected 4", nb1 - b0); end
    tests++;
    if (busy1 !== 1'b0) begin fails++; $display("FAIL basic_busy_fall: busy=%b expected 0", busy1); end
    tests++;
    if (bb1[b0+3] !== 1'b1) begin fails++; $display("FAIL basic_busy_last: busy=%b expected 1", bb1[b0+3]); end
    tests++;
    if (np1 - p0 !== 4) begin fails++; $display("FAIL basic_pops: got %0d expected 4", np1 - p0); end
    tests++;
    if (pcyc1[p0+3] - pcyc1[p0] !== 3) begin
      fails++; $display("FAIL basic_pop_span: got %0d expected 3", pcyc1[p0+3] - pcyc1[p0]);
    end
    tests++;
    if (bcyc1[b0] - pcyc1[p0] !== 2) begin
      fails++; $display("FAIL basic_latency: got %0d expected 2", bcyc1[b0] - pcyc1[p0]);
    end
    tests++;
    if (bcyc1[b0+3] - bcyc1[b0] !== 3) begin
      fails++; $display("FAIL basic_beat_span: got %0d expected 3", bcyc1[b0+3] - bcyc1[b0]);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 32'hA0 + W'(i);
      tests++;
      if (bd1[b0+i] !== exp || bl1[b0+i] !== (i == 3)) begin
        fails++;
        $display("FAIL basic_beat%0d: data=%0h last=%b expected %0h %b", i, bd1[b0+i], bl1[b0+i], exp, i == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    int p0, b0, g;
    logic [W-1:0] exp;
    load1(8, 32'hB0);
    p0 = np1; b0 = nb1; g = 0;
    out_ready = 1'b0;
    send_req(16'd8);
    repeat (10) tick();
    tests++;
    if (np1 - p0 !== 4 || pop1 !== 1'b0) begin
      fails++; $display("FAIL bp_stall: pops=%0d pop=%b expected 4 0", np1 - p0, pop1);
    end
    tests++;
    if (out_valid1 !== 1'b1 || wl1 !== 16'd8) begin
      fails++; $display("FAIL bp_hold: valid=%b words_left=%0d expected 1 8", out_valid1, wl1);
    end
    out_ready = 1'b1;
    while (nb1 < b0 + 8 && g < 60) begin tick(); g++; end
    tests++;
    if (np1 - p0 !== 8 || g >= 60) begin
      fails++; $display("FAIL bp_total: pops=%0d beats=%0d expected 8 8", np1 - p0, nb1 - b0);
    end
    for (int i = 0; i < 8; i++) begin
      exp = 32'hB0 + W'(i);
      tests++;
      if (bd1[b0+i] !== exp || bw1[b0+i] !== LW'(8 - i) || bl1[b0+i] !== (i == 7)) begin
        fails++;
        $display("FAIL bp_beat%0d: data=%0h wl=%0d last=%b expected %0h %0d %b", i,
                 bd1[b0+i], bw1[b0+i], bl1[b0+i], exp, 8 - i, i == 7);
      end
    end
    tests++;
    if (wl1 !== 16'd0 || busy1 !== 1'b0) begin
      fails++; $display("FAIL bp_end: words_left=%0d busy=%b expected 0 0", wl1, busy1);
    end
  endtask

  task automatic test_empty_toggle();
    int p0, b0, v0, g;
    logic [W-1:0] exp;
    load1(3, 32'hC0);
    p0 = np1; b0 = nb1; v0 = viol1; g = 0;
    send_req(16'd3);
    while (nb1 < b0 + 3 && g < 40) begin
      empty_force = ~empty_force;
      tick();
      g++;
    end
    empty_force = 1'b0;
    tests++;
    if (viol1 - v0 !== 0) begin fails++; $display("FAIL empty_pop: pops while empty=%0d expected 0", viol1 - v0); end
    tests++;
    if (np1 - p0 !== 3 || g >= 40) begin
      fails++; $display("FAIL empty_total: pops=%0d beats=%0d expected 3 3", np1 - p0, nb1 - b0);
    end
    for (int i = 0; i < 3; i++) begin
      exp = 32'hC0 + W'(i);
      tests++;
      if (bd1[b0+i] !== exp || bl1[b0+i] !== (i == 2)) begin
        fails++;
        $display("FAIL empty_beat%0d: data=%0h last=%b expected %0h %b", i, bd1[b0+i], bl1[b0+i], exp, i == 2);
      end
    end
  endtask

  task automatic test_zero_len();
    int p0;
    load1(1, 32'hD0);
    p0 = np1;
    req_valid = 1'b1;
    req_len   = 16'd0;
    #1;
    tests++;
    if (req_ready1 !== 1'b1) begin fails++; $display("FAIL zero_accept: req_ready=%b expected 1", req_ready1); end
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    tests++;
    if (np1 !== p0 || busy1 !== 1'b0 || req_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL zero_idle: pops=%0d busy=%b ready=%b expected 0 0 1", np1 - p0, busy1, req_ready1);
    end
  endtask

  task automatic test_latency2_reset();
    int b0, b1, p1, g, base;
    rst1 = 1'b1;
    load2(8, 32'hE0);
    rst2 = 1'b0;
    tick();
    tests++;
    if (req_ready2 !== 1'b1) begin fails++; $display("FAIL l2_ready: req_ready=%b expected 1", req_ready2); end
    b0 = nb2; g = 0;
    send_req(16'd6);
    while (nb2 < b0 + 2 && g < 40) begin tick(); g++; end
    tests++;
    if (g >= 40 || bd2[b0] !== 32'hE0 || bd2[b0+1] !== 32'hE1) begin
      fails++; $display("FAIL l2_first_beats: data=%0h %0h expected e0 e1", bd2[b0], bd2[b0+1]);
    end
    rst2 = 1'b1;
    tick();
    tests++;
    if ({pop2, out_valid2, busy2, req_ready2, out_last2} !== 5'b0 || wl2 !== '0 || out_data2 !== '0) begin
      fails++;
      $display("FAIL l2_reset_outputs: flags=%b wl=%0d data=%0h expected 0", 
               {pop2, out_valid2, busy2, req_ready2, out_last2}, wl2, out_data2);
    end
    rst2 = 1'b0;
    tick();
    tests++;
    if (req_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      fails++; $display("FAIL l2_post_reset: ready=%b valid=%b expected 1 0", req_ready2, out_valid2);
    end
    base = rp2; p1 = np2; b1 = nb2; g = 0;
    send_req(16'd2);
    while (nb2 < b1 + 2 && g < 40) begin tick(); g++; end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (bd2[b1+i] !== mem2[base+i] || bl2[b1+i] !== (i == 1)) begin
        fails++;
        $display("FAIL l2_new_beat%0d: data=%0h last=%b expected %0h %b", i, bd2[b1+i], bl2[b1+i],
                 mem2[base+i], i == 1);
      end
    end
    tests++;
    if (np2 - p1 !== 2 || viol2 !== 0) begin
      fails++; $display("FAIL l2_pops: pops=%0d empty_pops=%0d expected 2 0", np2 - p1, viol2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_toggle();
    test_zero_len();
    test_latency2_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
